mutative_cacheline_adapter: RTL
===============================

// Module: mutative_cacheline_adapter
// PURPOSE
//  Downstream neighbour of mutative_cache; sits on its dfp port.
//  Converts single-cycle 256-bit line read/write requests into 4-beat x 64-bit
//  bursts on the burst-memory (bmem) port.
//  Reassembles read bursts into a full line and returns one dfp_resp per request.
// PARAMETERS
//  LINE_BITS   256  cacheline width; must match the cache's CACHELINE_SIZE
//  BEAT_BITS   64   bmem data width per beat
//  BURST_LEN   LINE_BITS/BEAT_BITS (4)  derived localparam, not overridable
// PORTS
//  clk         input   1    single clock, rising edge
//  rst         input   1    asynchronous, active-low reset
//  dfp_addr    input   32   line address from cache; bits [4:0] ignored
//  dfp_read    input   1    line read request, held until dfp_resp
//  dfp_write   input   1    line write request, held until dfp_resp
//  dfp_wdata   input   256  line write data, valid while dfp_write is high
//  dfp_rdata   output  256  assembled read line, valid when dfp_resp is high
//  dfp_resp    output  1    one-cycle completion pulse
//  bmem_addr   output  32   line-aligned burst address {addr[31:5],5'b0}
//  bmem_read   output  1    read-burst command, one cycle
//  bmem_write  output  1    write beat valid
//  bmem_wdata  output  64   write beat data
//  bmem_ready  input   1    memory accepts the command or beat this cycle
//  bmem_raddr  input   32   address tag of the returning read beat
//  bmem_rdata  input   64   read beat data
//  bmem_rvalid input   1    read beat valid
//  err         output  1    sticky: a read beat arrived with a mismatching raddr
// BEHAVIOUR
//  Reset (rst==0, async): state=IDLE, beat_cnt=0, err=0.
//   All outputs are 0; the line buffer is cleared.
//  A reset asserted mid-transaction abandons the burst; no dfp_resp is issued.
//  FSM states: IDLE, WR_BURST, RD_CMD, RD_BURST, RESP.
//  IDLE:
//   - dfp_write: latch addr and wdata -> WR_BURST.
//   - else dfp_read: latch addr -> RD_CMD.
//   - Write wins if both are high.
//   - Requests are sampled only in IDLE.
//  WR_BURST:
//   - bmem_write=1, bmem_addr=latched line addr, bmem_wdata=line[64*beat_cnt +: 64].
//   - beat_cnt increments only on a cycle where bmem_ready is high.
//   - When beat 3 is accepted -> RESP.
//   - bmem_ready low stalls with beat data and address held.
//  RD_CMD:
//   - bmem_read=1 with addr until a cycle where bmem_ready is high; then -> RD_BURST.
//   - bmem_read is high for exactly the accepting cycle plus any stall cycles.
//  RD_BURST:
//   - On bmem_rvalid with raddr==latched addr, write beat into line[64*beat_cnt +: 64] and increment.
//   - On bmem_rvalid with raddr!=latched addr, drop the beat and set err.
//   - After beat 3 is captured -> RESP.
//   - Gaps between beats are legal.
//   - Beats are in order: lowest 64 bits first.
//  RESP:
//   - dfp_resp=1 for exactly one cycle.
//   - dfp_rdata = assembled line (reads); dfp_rdata = 0 for writes.
//   - beat_cnt <= 0, then -> IDLE.
//   - The cache drops its request the cycle after dfp_resp.
//   - IDLE may accept a new request 1 cycle after RESP.
//  Latency:
//   - Write with ready always high: dfp_resp 5 cycles after the request cycle.
//   - Read: dfp_resp 1 cycle after the last beat.
//  beat_cnt is 2 bits and wraps 3->0 only through RESP.
//  bmem_rvalid outside RD_BURST is ignored and does not set err.
//  dfp_wdata and dfp_addr changes after acceptance have no effect.
// STRUCTURE
//  mutative_types gains:
//   - BEAT_BITS, BURST_LEN constants.
//   - typedef enum logic [2:0] adapter_state_t {IDLE, WR_BURST, RD_CMD, RD_BURST, RESP}.
//  Single module, no sub-module: FSM + 2-bit beat counter + 256-bit line buffer (shared by read and write).
// TESTING
//  1. Write: dfp_write, addr=0x0000_1234, wdata={64'hD,64'hC,64'hB,64'hA}, ready=1
//     -> beats A,B,C,D at bmem_addr=0x0000_1220; dfp_resp on cycle 5.
//  2. Read: dfp_read addr=0x8000_0040; 4 beats 1,2,3,4 with 2-cycle gaps
//     -> dfp_rdata={64'h4,64'h3,64'h2,64'h1}; one dfp_resp pulse.
//  3. Backpressure: ready low for 3 cycles mid write-burst after beat 1
//     -> beat 2 data held stable; exactly 4 accepted beats; one resp.
//  4. Both dfp_read and dfp_write high in IDLE
//     -> write burst issued; no bmem_read.
//  5. Read beat with raddr=0x0 while latched addr=0x40
//     -> beat dropped, err=1 and stays 1, transfer completes after 4 matching beats.
//  6. rst low during beat 2 of a read
//     -> outputs 0 immediately; after release a new read completes correctly.

Source files
------------

// File: rtl/mutative_cacheline_adapter_pkg.sv
// Shared constants, FSM state type and address helper for the cacheline-to-burst adapter.
package mutative_cacheline_adapter_pkg;

  localparam int unsigned ADP_ADDR_BITS = 32;
  localparam int unsigned ADP_LINE_BITS = 256;
  localparam int unsigned ADP_BEAT_BITS = 64;
  localparam int unsigned ADP_BURST_LEN = ADP_LINE_BITS / ADP_BEAT_BITS;

  typedef enum logic [2:0] {
    IDLE,
    WR_BURST,
    RD_CMD,
    RD_BURST,
    RESP
  } adapter_state_t;

  // Clears the byte-offset bits so the address points at the start of its line.
  function automatic logic [ADP_ADDR_BITS-1:0] line_align(
    input logic [ADP_ADDR_BITS-1:0] addr,
    input int unsigned              offs_bits
  );
    return addr & ~((32'd1 << offs_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/mutative_cacheline_adapter_if.sv
// Cache-facing line port (dfp) plus burst-memory port (bmem) of the adapter.
interface mutative_cacheline_adapter_if #(
  parameter int unsigned LINE_BITS = mutative_cacheline_adapter_pkg::ADP_LINE_BITS,
  parameter int unsigned BEAT_BITS = mutative_cacheline_adapter_pkg::ADP_BEAT_BITS
);

  logic [31:0]          dfp_addr;
  logic                 dfp_read;
  logic                 dfp_write;
  logic [LINE_BITS-1:0] dfp_wdata;
  logic [LINE_BITS-1:0] dfp_rdata;
  logic                 dfp_resp;

  logic [31:0]          bmem_addr;
  logic                 bmem_read;
  logic                 bmem_write;
  logic [BEAT_BITS-1:0] bmem_wdata;
  logic                 bmem_ready;
  logic [31:0]          bmem_raddr;
  logic [BEAT_BITS-1:0] bmem_rdata;
  logic                 bmem_rvalid;

  logic                 err;

  // The adapter itself.
  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    output err
  );

  // The surrounding cache and memory.
  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    input  err
  );

endinterface

// File: rtl/mutative_cacheline_adapter.sv
// Splits 256-bit line requests into 4 x 64-bit bmem bursts and reassembles read
// bursts into a single line response.
module mutative_cacheline_adapter
  import mutative_cacheline_adapter_pkg::*;
#(
  parameter int unsigned LINE_BITS = ADP_LINE_BITS,
  parameter int unsigned BEAT_BITS = ADP_BEAT_BITS
) (
  input logic                          clk,
  input logic                          rst,
  mutative_cacheline_adapter_if.slave  bus
);

  localparam int unsigned BURST_LEN = LINE_BITS / BEAT_BITS;
  localparam int unsigned CNT_BITS  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned OFFS_BITS = $clog2(LINE_BITS / 8);
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BURST_LEN - 1);

  adapter_state_t       r_state;
  logic [CNT_BITS-1:0]  r_beat_cnt;
  logic [LINE_BITS-1:0] r_line;
  logic [31:0]          r_addr;
  logic                 r_bmem_read;
  logic                 r_bmem_write;
  logic [BEAT_BITS-1:0] r_bmem_wdata;
  logic                 r_dfp_resp;
  logic [LINE_BITS-1:0] r_dfp_rdata;
  logic                 r_err;

  logic [CNT_BITS-1:0]  w_cnt_next;
  logic                 w_beat_hit;
  logic [LINE_BITS-1:0] w_line_fill;

  assign w_cnt_next = r_beat_cnt + 1'b1;
  assign w_beat_hit = bus.bmem_rvalid && (bus.bmem_raddr == r_addr);

  // Line buffer with the incoming beat merged in, so the final beat can be
  // presented on dfp_rdata in the same edge that captures it.
  always_comb begin
    w_line_fill = r_line;
    w_line_fill[BEAT_BITS*r_beat_cnt +: BEAT_BITS] = bus.bmem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_beat_cnt   <= '0;
      r_line       <= '0;
      r_addr       <= '0;
      r_bmem_read  <= 1'b0;
      r_bmem_write <= 1'b0;
      r_bmem_wdata <= '0;
      r_dfp_resp   <= 1'b0;
      r_dfp_rdata  <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.dfp_write) begin
            r_addr       <= line_align(bus.dfp_addr, OFFS_BITS);
            r_line       <= bus.dfp_wdata;
            r_bmem_wdata <= bus.dfp_wdata[BEAT_BITS-1:0];
            r_bmem_write <= 1'b1;
            r_state      <= WR_BURST;
          end else if (bus.dfp_read) begin
            r_addr      <= line_align(bus.dfp_addr, OFFS_BITS);
            r_bmem_read <= 1'b1;
            r_state     <= RD_CMD;
          end
        end

        WR_BURST: begin
          if (bus.bmem_ready) begin
            if (r_beat_cnt == LAST_BEAT) begin
              r_bmem_write <= 1'b0;
              r_bmem_wdata <= '0;
              r_dfp_resp   <= 1'b1;
              r_dfp_rdata  <= '0;
              r_state      <= RESP;
            end else begin
              r_beat_cnt   <= w_cnt_next;
              r_bmem_wdata <= r_line[BEAT_BITS*w_cnt_next +: BEAT_BITS];
            end
          end
        end

        RD_CMD: begin
          if (bus.bmem_ready) begin
            r_bmem_read <= 1'b0;
            r_state     <= RD_BURST;
          end
        end

        RD_BURST: begin
          if (w_beat_hit) begin
            r_line <= w_line_fill;
            if (r_beat_cnt == LAST_BEAT) begin
              r_dfp_resp  <= 1'b1;
              r_dfp_rdata <= w_line_fill;
              r_state     <= RESP;
            end else begin
              r_beat_cnt <= w_cnt_next;
            end
          end else if (bus.bmem_rvalid) begin
            r_err <= 1'b1;
          end
        end

        RESP: begin
          r_dfp_resp  <= 1'b0;
          r_dfp_rdata <= '0;
          r_beat_cnt  <= '0;
          r_state     <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.dfp_rdata  = r_dfp_rdata;
  assign bus.dfp_resp   = r_dfp_resp;
  assign bus.bmem_addr  = r_addr;
  assign bus.bmem_read  = r_bmem_read;
  assign bus.bmem_write = r_bmem_write;
  assign bus.bmem_wdata = r_bmem_wdata;
  assign bus.err        = r_err;

endmodule
